symbol_packer: RTL and testbench

SYMBOL_PACKER -- requirements
Module: symbol_packer

---
 rtl/symbol_pkg.sv | 28 ++
 rtl/symbol_packer_if.sv | 24 ++
 rtl/symbol_packer.sv | 88 ++++++++
 tb/tb_symbol_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/symbol_pkg.sv
// Shared constants for the 8PSK symbol/byte conversion, used by both the
// receive-side packer and the transmit-side shifter.
package symbol_pkg;

  localparam int SYM_W     = 3;
  localparam int BYTE_W    = 8;
  localparam int GROUP_LEN = 8;
  localparam int PHASE_W   = $clog2(GROUP_LEN);
  // Largest residue held between symbols is 7 bits (ahead of the phase-5 symbol).
  localparam int CARRY_W   = BYTE_W - 1;
  localparam int ACC_W     = CARRY_W + SYM_W;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t PH_BYTE0 = 3'd2;
  localparam phase_t PH_BYTE1 = 3'd5;
  localparam phase_t PH_BYTE2 = 3'd7;

  // Bits already held in the carry register when the symbol at phase p arrives.
  function automatic int bits_held(input phase_t p);
    return (int'(p) * SYM_W) % BYTE_W;
  endfunction

  function automatic logic is_complete(input phase_t p);
    return (p == PH_BYTE0) || (p == PH_BYTE1) || (p == PH_BYTE2);
  endfunction

endpackage

// File: rtl/symbol_packer_if.sv
// Symbol-in / byte-out bundle between a demodulator (master) and the packer (slave).
interface symbol_packer_if;

  logic [symbol_pkg::SYM_W-1:0]  sym;
  logic                          sym_valid;
  logic                          sync;
  logic                          hold;
  logic [symbol_pkg::BYTE_W-1:0] data;
  logic                          byte_valid;
  logic                          byte_ready;
  logic                          overflow;
  logic                          clr_ovf;

  modport master (
    output sym, sym_valid, sync, hold, byte_ready, clr_ovf,
    input  data, byte_valid, overflow
  );

  modport slave (
    input  sym, sym_valid, sync, hold, byte_ready, clr_ovf,
    output data, byte_valid, overflow
  );

endinterface

// File: rtl/symbol_packer.sv
// Packs a continuous MSB-first stream of 3-bit symbols into bytes; 8 symbols
// make 3 bytes. One-deep output register with valid/ready and a sticky overflow.
module symbol_packer
  import symbol_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  symbol_packer_if.slave bus
);

  phase_t              phase_q, phase_d;
  logic [CARRY_W-1:0]  carry_q, carry_d;
  logic [BYTE_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                ovf_q,   ovf_d;

  logic                accept;
  logic                start;
  logic                complete;
  logic                ovf_set;
  phase_t              cur_phase;
  logic [CARRY_W-1:0]  cur_carry;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    keep_mask;
  logic [3:0]          left_bits;
  logic [BYTE_W-1:0]   new_byte;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; the async reset clears all state, partial bits included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      carry_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      carry_q <= carry_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Assembly path: a sync symbol restarts the group with an empty carry.
  always_comb begin
    accept    = bus.sym_valid & ~bus.hold;
    start     = accept & bus.sync;
    cur_phase = start ? '0 : phase_q;
    cur_carry = start ? '0 : carry_q;
    acc       = {cur_carry, bus.sym};
    complete  = accept & is_complete(cur_phase);
    left_bits = complete ? 4'(bits_held(cur_phase) + SYM_W - BYTE_W) : 4'd0;
    keep_mask = (ACC_W'(1) << left_bits) - ACC_W'(1);
    new_byte  = BYTE_W'(acc >> left_bits);

    phase_d = phase_q;
    carry_d = carry_q;
    if (accept) begin
      phase_d = cur_phase + phase_t'(1);
      carry_d = complete ? CARRY_W'(acc & keep_mask) : CARRY_W'(acc);
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_set = 1'b0;
    if (complete) begin
      if (!valid_q || bus.byte_ready) begin
        data_d  = new_byte;
        valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.byte_ready) begin
      valid_d = 1'b0;
    end
    ovf_d = ovf_set | (ovf_q & ~bus.clr_ovf);
  end

  assign bus.data       = data_q;
  assign bus.byte_valid = valid_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed scenarios plus randomized traffic for symbol_packer, checked against
// a bit-queue reference model and fixed expected byte sequences.
module tb_symbol_packer;
  import symbol_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  symbol_packer_if bus();

  symbol_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit         mq[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf;
  logic [7:0] got_q[$];

  logic [2:0] seq [8]       = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd3, 3'd7, 3'd7};
  logic [7:0] exp_bytes [3] = '{8'hA5, 8'h3C, 8'hFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Reference: bits go into a FIFO; every time 8 are available a byte is born.
  task automatic model_step();
    bit [7:0] nb = '0;
    bit done = 1'b0;
    bit drop = 1'b0;
    if (bus.sym_valid && !bus.hold) begin
      if (bus.sync) mq.delete();
      for (int b = 2; b >= 0; b--) mq.push_back(bus.sym[b]);
      if (mq.size() >= 8) begin
        for (int b = 0; b < 8; b++) nb = {nb[6:0], mq.pop_front()};
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || bus.byte_ready) begin
        m_data  = nb;
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (bus.byte_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic tick();
    if (bus.byte_valid && bus.byte_ready) got_q.push_back(bus.data);
    model_step();
    @(posedge clk);
    #1;
    check("model_data",  bus.data,       m_data);
    check("model_valid", bus.byte_valid, m_valid);
    check("model_ovf",   bus.overflow,   m_ovf);
  endtask

  task automatic idle_inputs();
    bus.sym       = '0;
    bus.sym_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.hold      = 1'b0;
    bus.clr_ovf   = 1'b0;
  endtask

  task automatic send(input logic [2:0] s, input logic sy);
    bus.sym       = s;
    bus.sym_valid = 1'b1;
    bus.sync      = sy;
    tick();
    bus.sym_valid = 1'b0;
    bus.sync      = 1'b0;
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), 3);
    for (int k = 0; k < 3; k++)
      check(tag, (k < got_q.size()) ? {24'h0, got_q[k]} : 32'hDEAD, exp_bytes[k]);
  endtask

  // Called just after an edge: drops reset between edges and checks it bites at once.
  task automatic async_reset_pulse();
    #3 reset_n = 1'b0;
    #1;
    check("rst_async_data",  bus.data,       8'h00);
    check("rst_async_valid", bus.byte_valid, 1'b0);
    check("rst_async_ovf",   bus.overflow,   1'b0);
    model_reset();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    bus.byte_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_data",  bus.data,       8'h00);
    check("reset_valid", bus.byte_valid, 1'b0);
    check("reset_ovf",   bus.overflow,   1'b0);
    #2 reset_n = 1'b1;

    // Basic group with an always-ready consumer.
    bus.byte_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(seq[i], 1'b0);
      check("basic_valid", bus.byte_valid, (i == 2 || i == 5 || i == 7));
    end
    tick();
    check_bytes("basic_bytes");

    // Hold on alternate cycles with junk on the held symbols.
    got_q.delete();
    bus.sym_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.hold = c[0];
      bus.sym  = c[0] ? 3'($urandom) : seq[c / 2];
      tick();
    end
    idle_inputs();
    tick();
    check_bytes("hold_bytes");

    // Stalled consumer: first byte persists, later ones overflow.
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(seq[i], 1'b0);
      if (i == 2) check("stall_first", bus.data, 8'hA5);
      if (i == 4) check("stall_ovf_early", bus.overflow, 1'b0);
      if (i == 5) check("stall_ovf_set", bus.overflow, 1'b1);
    end
    check("stall_data_kept", bus.data, 8'hA5);
    check("stall_valid_kept", bus.byte_valid, 1'b1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("clr_ovf", bus.overflow, 1'b0);
    bus.byte_ready = 1'b1;
    tick();
    check("stall_drained", bus.byte_valid, 1'b0);

    // Resync after a partial group.
    for (int i = 0; i < 4; i++) send(3'($urandom), 1'b0);
    tick();
    got_q.delete();
    for (int i = 0; i < 8; i++) send(seq[i], (i == 0));
    tick();
    check_bytes("sync_bytes");

    // Ready arrives exactly when the second byte completes.
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(seq[i], 1'b0);
    check("replace_pending", bus.data, 8'hA5);
    bus.byte_ready = 1'b1;
    send(seq[5], 1'b0);
    check("replace_data",  bus.data,       8'h3C);
    check("replace_valid", bus.byte_valid, 1'b1);
    check("replace_ovf",   bus.overflow,   1'b0);
    send(seq[6], 1'b0);
    send(seq[7], 1'b0);
    tick();

    // Asynchronous reset in the middle of a group.
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(seq[i], 1'b0);
    check("prereset_valid", bus.byte_valid, 1'b1);
    async_reset_pulse();
    bus.byte_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 8; i++) send(seq[i], 1'b0);
    tick();
    check_bytes("postreset_bytes");

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      bus.sym        = 3'($urandom);
      bus.sym_valid  = ($urandom_range(0, 9) < 7);
      bus.hold       = ($urandom_range(0, 9) < 2);
      bus.sync       = ($urandom_range(0, 19) == 0);
      bus.byte_ready = ($urandom_range(0, 9) < 6);
      bus.clr_ovf    = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
